// File: rtl/exe_mem_stage_pkg.sv
// Shared execute-stage definitions: ALU opcodes, MUL FSM states
// and the EXE/MEM control bundle.
package exe_mem_stage_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;
    localparam logic [2:0] ALU_RSV = 3'b111;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    typedef struct packed {
        logic wen;
        logic memwrite;
        logic memread;
        logic memtoreg;
        logic branch_taken;
    } ex_mem_ctl_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return op == ALU_MUL;
    endfunction

endpackage

// File: rtl/exe_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle,
// DSIZE steps, low DSIZE bits of the product.
module exe_mul_seq
    import exe_mem_stage_pkg::*;
#(
    parameter int DSIZE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [DSIZE-1:0] product
);

    localparam int CW = $clog2(DSIZE);
    localparam logic [CW-1:0] LAST = CW'(DSIZE - 1);

    mul_state_t       state_q;
    mul_state_t       state_d;
    logic [CW-1:0]    cnt_q;
    logic [DSIZE-1:0] mcand_q;
    logic [DSIZE-1:0] mplier_q;
    logic [DSIZE-1:0] acc_q;

    // Next-state: abort always wins and drops any partial product.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MUL_IDLE: if (start) state_d = MUL_BUSY;
            MUL_BUSY: if (cnt_q == LAST) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
        if (abort) state_d = MUL_IDLE;
    end

    // State register plus operand latch and shift-add datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (!abort && state_q == MUL_IDLE && start) begin
                cnt_q    <= '0;
                mcand_q  <= a;
                mplier_q <= b;
                acc_q    <= '0;
            end else if (!abort && state_q == MUL_BUSY) begin
                cnt_q    <= cnt_q + CW'(1);
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
            end
        end
    end

    assign busy    = state_q == MUL_BUSY;
    assign done    = state_q == MUL_DONE;
    assign product = acc_q;

endmodule

// File: rtl/exe_mem_stage.sv
// Execute stage (ALU, operand select, branch resolve/target) and
// the EXE/MEM pipeline register; MUL stalls the front of the pipe.
module exe_mem_stage
    import exe_mem_stage_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5,
    parameter int ISIZE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DSIZE-1:0] rdata1_in,
    input  logic [DSIZE-1:0] rdata2_in,
    input  logic [DSIZE-1:0] imm_in,
    input  logic [2:0]       aluop_in,
    input  logic             alusrc_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic [ISIZE-1:0] PCIN_in,
    input  logic             wen_in,
    input  logic             branch_in,
    input  logic             memwrite_in,
    input  logic             memread_in,
    input  logic             memtoreg_in,
    output logic [DSIZE-1:0] alu_result_out,
    output logic [DSIZE-1:0] rdata2_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic             wen_out,
    output logic             memwrite_out,
    output logic             memread_out,
    output logic             memtoreg_out,
    output logic             branch_taken_out,
    output logic [ISIZE-1:0] branch_target_out,
    output logic             stall_out
);

    logic [DSIZE-1:0] op_b;
    logic [DSIZE-1:0] alu_res;
    logic             zero;
    logic [ISIZE-1:0] target;
    logic             mul_busy;
    logic             mul_done;
    logic             mul_start;
    logic [DSIZE-1:0] mul_prod;
    ex_mem_ctl_t      ctl_d;
    ex_mem_ctl_t      ctl_q;

    assign op_b   = alusrc_in ? imm_in : rdata2_in;
    assign zero   = alu_res == '0;
    assign target = PCIN_in + imm_in[ISIZE-1:0];

    // Single-cycle ALU; MUL and the reserved code give 0 here.
    always_comb begin
        alu_res = '0;
        unique case (aluop_in)
            ALU_ADD: alu_res = rdata1_in + op_b;
            ALU_SUB: alu_res = rdata1_in - op_b;
            ALU_AND: alu_res = rdata1_in & op_b;
            ALU_OR:  alu_res = rdata1_in | op_b;
            ALU_XOR: alu_res = rdata1_in ^ op_b;
            ALU_SLT: alu_res = {{(DSIZE-1){1'b0}},
                                $signed(rdata1_in) < $signed(op_b)};
            ALU_MUL: alu_res = '0;
            ALU_RSV: alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    // A held MUL in DONE must not retrigger, so start only from idle.
    assign mul_start = is_mul_op(aluop_in) && !mul_busy
                       && !mul_done && !flush;
    assign stall_out = !flush && (mul_start || mul_busy);

    exe_mul_seq #(
        .DSIZE(DSIZE)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .abort  (flush),
        .a      (rdata1_in),
        .b      (op_b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_prod)
    );

    // Control for the next EXE/MEM entry; bubble on flush or stall.
    always_comb begin
        ctl_d              = '0;
        ctl_d.wen          = wen_in;
        ctl_d.memwrite     = memwrite_in;
        ctl_d.memread      = memread_in;
        ctl_d.memtoreg     = memtoreg_in;
        ctl_d.branch_taken = branch_in && zero;
        if (flush || stall_out) ctl_d = '0;
    end

    // EXE/MEM register; data fields load every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_out    <= '0;
            rdata2_out        <= '0;
            waddr_out         <= '0;
            branch_target_out <= '0;
            ctl_q             <= '0;
        end else begin
            alu_result_out    <= mul_done ? mul_prod : alu_res;
            rdata2_out        <= rdata2_in;
            waddr_out         <= waddr_in;
            branch_target_out <= target;
            ctl_q             <= ctl_d;
        end
    end

    assign wen_out          = ctl_q.wen;
    assign memwrite_out     = ctl_q.memwrite;
    assign memread_out      = ctl_q.memread;
    assign memtoreg_out     = ctl_q.memtoreg;
    assign branch_taken_out = ctl_q.branch_taken;

endmodule
